// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding and block geometry for the SHA-256 padder
package sha256_pkg;
  typedef enum logic [1:0] {S_FILL, S_DATA, S_TAIL, S_EXTRA} state_e;
  localparam int BLK_BYTES = 64;
  localparam int LEN_POS = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;
endpackage

// File: rtl/sha256_pad_mux.sv
// sha256_pad_mux: combinational assembly of data, tail and extra-length blocks
module sha256_pad_mux
  import sha256_pkg::*;
(
  input  state_e       i_mode,
  input  logic [511:0] i_buf,
  input  logic [6:0]   i_n,
  input  logic [63:0]  i_len,
  output logic [511:0] o_blk
);
  logic w_short;
  logic w_full;
  assign w_short = i_n <= 7'(LEN_POS - 1);
  assign w_full = i_n == 7'(BLK_BYTES);
  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_byte
    localparam int pos = (BLK_BYTES - 1 - g) * 8;
    logic [7:0] w_raw;
    logic [7:0] w_pad;
    logic [7:0] w_tail;
    logic [7:0] w_extra;
    assign w_raw = i_buf[pos +: 8];
    // Held bytes pass through, the first free slot gets the terminator, the rest are zero
    assign w_pad = 7'(g) < i_n ? w_raw : 7'(g) == i_n ? PAD_BYTE : 8'h00;
    if (g >= LEN_POS) begin : g_len
      assign w_tail = w_short ? i_len[pos +: 8] : w_pad;
      assign w_extra = i_len[pos +: 8];
    end else begin : g_body
      assign w_tail = w_pad;
      assign w_extra = (g == 0 && w_full) ? PAD_BYTE : 8'h00;
    end
    assign o_blk[pos +: 8] = i_mode == S_DATA  ? w_raw  :
                             i_mode == S_TAIL  ? w_tail :
                             i_mode == S_EXTRA ? w_extra : 8'h00;
  end
endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: byte stream to padded 512-bit SHA-256 blocks with first/last flags
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);
  state_e r_state;
  state_e w_next;
  logic [511:0] r_buf;
  logic [5:0] r_ptr;
  logic [6:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic r_first;
  logic [CNT_W+2:0] w_bits;
  logic [63:0] w_len;
  logic w_in_fire;
  logic w_blk_fire;
  logic w_short;
  assign w_bits = {r_cnt, 3'b000};
  assign w_len = 64'(w_bits);
  assign w_in_fire = in_valid && in_ready;
  assign w_blk_fire = blk_valid && blk_ready;
  assign w_short = r_n <= 7'(LEN_POS - 1);
  assign blk_first = blk_valid && r_first;
  assign blk_last = (r_state == S_TAIL && w_short) || r_state == S_EXTRA;
  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_FILL;
    else r_state <= w_next;
  end
  // Next state and handshake outputs
  always_comb begin
    w_next = r_state;
    in_ready = 1'b0;
    blk_valid = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) w_next = in_last ? S_TAIL : (r_ptr == 6'd63 ? S_DATA : S_FILL);
      end
      S_DATA: begin
        blk_valid = 1'b1;
        if (blk_ready) w_next = S_FILL;
      end
      S_TAIL: begin
        blk_valid = 1'b1;
        if (blk_ready) w_next = w_short ? S_FILL : S_EXTRA;
      end
      S_EXTRA: begin
        blk_valid = 1'b1;
        if (blk_ready) w_next = S_FILL;
      end
      default: w_next = S_FILL;
    endcase
  end
  // Byte buffer; never read beyond the bytes written for the current block, so no reset
  always_ff @(posedge clk_clk) begin
    if (r_state == S_FILL && w_in_fire) r_buf[{6'd63 - r_ptr, 3'b000} +: 8] <= in_data;
  end
  // Write pointer, tail count, byte counter and first-block flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ptr <= '0;
      r_n <= '0;
      r_cnt <= '0;
      r_first <= 1'b1;
    end else if (r_state == S_FILL && w_in_fire) begin
      r_cnt <= r_cnt + 1'b1;
      if (in_last) r_n <= {1'b0, r_ptr} + 7'd1;
      else if (r_ptr != 6'd63) r_ptr <= r_ptr + 6'd1;
    end else if (w_blk_fire) begin
      if (r_state == S_DATA) begin
        r_ptr <= '0;
        r_first <= 1'b0;
      end else if (r_state == S_TAIL && !w_short) begin
        r_first <= 1'b0;
      end else begin
        r_ptr <= '0;
        r_cnt <= '0;
        r_first <= 1'b1;
      end
    end
  end
  sha256_pad_mux u_mux (
    .i_mode(r_state),
    .i_buf(r_buf),
    .i_n(r_n),
    .i_len(w_len),
    .o_blk(blk_data)
  );
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: table-driven message vectors plus stall and reset sequences
module tb_sha256_padder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = 8'h00;
  logic in_last = 1'b0;
  logic blk_valid;
  logic blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic blk_first;
  logic blk_last;

  typedef struct {logic [511:0] d; logic f; logic l;} blk_t;
  typedef struct {int len; int kind; int stall; int nblk; logic [63:0] bitlen;} vec_t;

  blk_t got[$];
  logic [511:0] exp_q[$];
  vec_t vec[6];
  int n_chk = 0;
  int n_err = 0;
  int stall_en = 0;
  int stall_cnt = 0;
  logic [511:0] hold;
  logic [511:0] abc_blk;

  sha256_padder dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data(blk_data),
    .blk_first(blk_first),
    .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int kind, input int i);
    return kind == 0 ? 8'h00 : kind == 1 ? 8'(i * 7 + 3) : 8'(8'h61 + i);
  endfunction

  // Downstream side: optional 5-cycle stall per block, stability checks, capture on transfer
  always @(negedge clk) begin
    if (blk_valid) begin
      if (stall_en != 0 && stall_cnt < 5) begin
        if (stall_cnt == 0) hold = blk_data;
        else chk("stall_data", blk_data, hold);
        chk("stall_in_ready", 512'(in_ready), 512'(0));
        blk_ready = 1'b0;
        stall_cnt++;
      end else begin
        blk_ready = 1'b1;
        stall_cnt = 0;
        got.push_back('{blk_data, blk_first, blk_last});
      end
    end else begin
      blk_ready = (stall_en == 0);
      stall_cnt = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data = b;
    in_last = l;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) begin
      n_chk++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    int t = 0;
    logic [7:0] p[$];
    logic [63:0] bl;
    logic [511:0] blk;
    got.delete();
    exp_q.delete();
    stall_en = v.stall;
    for (int i = 0; i < v.len; i++) p.push_back(gen(v.kind, i));
    for (int i = 0; i < v.len; i++) send_byte(p[i], i == v.len - 1);
    while (got.size() < v.nblk && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    stall_en = 0;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(v.len) << 3;
    for (int k = 7; k >= 0; k--) p.push_back(bl[k*8 +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[b*64 + j];
      exp_q.push_back(blk);
    end
    chk({tag, "_nblk"}, 512'(got.size()), 512'(v.nblk));
    for (int b = 0; b < exp_q.size() && b < got.size(); b++) begin
      chk($sformatf("%s_blk%0d_data", tag, b), got[b].d, exp_q[b]);
      chk($sformatf("%s_blk%0d_first", tag, b), 512'(got[b].f), 512'(b == 0));
      chk($sformatf("%s_blk%0d_last", tag, b), 512'(got[b].l), 512'(b == exp_q.size() - 1));
    end
    if (got.size() > 0) chk({tag, "_bitlen"}, 512'(got[got.size()-1].d[63:0]), 512'(v.bitlen));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
    chk({tag, "_blk_first"}, 512'(blk_first), 512'(0));
    chk({tag, "_blk_last"}, 512'(blk_last), 512'(0));
    chk({tag, "_blk_data"}, blk_data, 512'(0));
  endtask

  initial begin
    vec[0] = '{3, 2, 0, 1, 64'h18};
    vec[1] = '{55, 0, 0, 1, 64'h1B8};
    vec[2] = '{56, 1, 0, 2, 64'h1C0};
    vec[3] = '{64, 1, 0, 2, 64'h200};
    vec[4] = '{200, 1, 1, 4, 64'h640};
    vec[5] = '{3, 2, 0, 1, 64'h18};
    abc_blk = {32'h61626380, 416'h0, 64'h18};
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run(vec[i], $sformatf("v%0d", i));
      if (vec[i].kind == 2 && got.size() > 0) chk($sformatf("v%0d_abc_literal", i), got[0].d, abc_blk);
    end
    for (int i = 0; i < 30; i++) send_byte(gen(1, i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midmsg_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(vec[0], "post_reset");
    if (got.size() > 0) chk("post_reset_abc_literal", got[0].d, abc_blk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
